count_compare_irq: RTL and testbench

Downstream consumer of the user-project counter value. Watches the live `count` bus for matches against two programmable compare registers, and timestamps edges on one user I/O pad into a capture register. It drives the user-project `irq[2:0]` lines, which are otherwise tied low. Register access uses the same `valid`/`ready`/`wstrb` slave handshake as the counter, decoded from the Wishbone port in the user-project wrapper.

---
 rtl/count_compare_irq_pkg.sv | 43 ++++
 rtl/count_compare_irq_sync_edge_detect.sv | 37 +++
 rtl/count_compare_irq.sv | 160 ++++++++++++++++
 tb/tb_count_compare_irq.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_compare_irq_pkg.sv
// Shared definitions for count_compare_irq: register word indices, CTRL/STATUS
// bit positions, interrupt bit order and a byte-lane write-merge helper.
package count_compare_irq_pkg;

    // Register word indices (wbs_adr_i[4:2])
    localparam logic [2:0] CCI_CMP0    = 3'd0;
    localparam logic [2:0] CCI_CMP1    = 3'd1;
    localparam logic [2:0] CCI_CTRL    = 3'd2;
    localparam logic [2:0] CCI_STATUS  = 3'd3;
    localparam logic [2:0] CCI_CAPTURE = 3'd4;
    localparam logic [2:0] CCI_CAPCNT  = 3'd5;

    // CTRL bits
    localparam int unsigned CTRL_EN0      = 0;
    localparam int unsigned CTRL_EN1      = 1;
    localparam int unsigned CTRL_EN_CAP   = 2;
    localparam int unsigned CTRL_CAP_FALL = 3;
    localparam int unsigned CTRL_W        = 4;

    // STATUS bits (all write-1-to-clear)
    localparam int unsigned ST_PEND_CMP0 = 0;
    localparam int unsigned ST_PEND_CMP1 = 1;
    localparam int unsigned ST_PEND_CAP  = 2;
    localparam int unsigned ST_CAP_OVF   = 3;

    // irq[2:0] = {cap, cmp1, cmp0}
    localparam int unsigned IRQ_CMP0 = 0;
    localparam int unsigned IRQ_CMP1 = 1;
    localparam int unsigned IRQ_CAP  = 2;

    // Replace the byte lanes of old_val selected by strb with those of new_val.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/count_compare_irq_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser for an asynchronous pad input followed
// by a single-cycle edge detector with selectable polarity.
//
// Ports:
//   clk      in  clock
//   reset    in  synchronous, active-high; all flops clear to 0
//   async_in in  asynchronous pad level
//   fall     in  0 = detect rising edge, 1 = detect falling edge
//   pulse    out one-cycle pulse on the selected edge (combinational from flops)
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    input  logic fall,
    output logic pulse
);

    logic sync1, sync2, sync3;

    // sync1/sync2 form the synchroniser; sync3 is the one-cycle history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_comb begin
        pulse = fall ? (sync3 & ~sync2) : (sync2 & ~sync3);
    end

endmodule

// File: rtl/count_compare_irq.sv
// count_compare_irq: watches the live counter value against two compare
// registers and timestamps pad edges into a capture register, raising the
// user-project irq[2:0] lines. Registers are reached through a
// valid/ready/wstrb slave handshake (one access per two cycles).
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high
//   count  in  live counter value [BITS]
//   evt_in in  asynchronous pad input for capture
//   valid  in  access request
//   addr   in  word index [3]
//   wstrb  in  byte write strobes, all zero = read [4]
//   wdata  in  write data [32]
//   ready  out one-cycle access acknowledge
//   rdata  out registered read data [32]
//   irq    out {cap, cmp1, cmp0} interrupts [3]
module count_compare_irq
    import count_compare_irq_pkg::*;
#(
    parameter int unsigned BITS  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] count,
    input  logic            evt_in,
    input  logic            valid,
    input  logic [2:0]      addr,
    input  logic [3:0]      wstrb,
    input  logic [31:0]     wdata,
    output logic            ready,
    output logic [31:0]     rdata,
    output logic [2:0]      irq
);

    logic [BITS-1:0]   cmp0_q, cmp0_d, cmp1_q, cmp1_d;
    logic [BITS-1:0]   capture_q, capture_d;
    logic [CNT_W-1:0]  capcnt_q, capcnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [2:0]        pend_q, pend_d;
    logic              cap_ovf_q, cap_ovf_d;
    logic              eq0_q, eq1_q;
    logic              ready_q;
    logic [31:0]       rdata_q, rdata_d;

    logic        accept, wr_en, rd_en;
    logic        eq0, eq1;
    logic        edge_pulse, cap_evt;
    logic [2:0]  hw_set;
    logic [3:0]  w1c;
    logic [31:0] cmp0_wr, cmp1_wr;

    sync_edge_detect u_evt_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (evt_in),
        .fall     (ctrl_q[CTRL_CAP_FALL]),
        .pulse    (edge_pulse)
    );

    always_comb begin
        accept  = valid & ~ready_q;
        wr_en   = accept & (|wstrb);
        rd_en   = accept & ~(|wstrb);

        eq0     = (count == cmp0_q);
        eq1     = (count == cmp1_q);
        // Edges are dropped entirely while capture is disabled.
        cap_evt = edge_pulse & ctrl_q[CTRL_EN_CAP];

        hw_set               = 3'b000;
        hw_set[ST_PEND_CMP0] = eq0 & ~eq0_q;
        hw_set[ST_PEND_CMP1] = eq1 & ~eq1_q;
        hw_set[ST_PEND_CAP]  = cap_evt;

        w1c = 4'b0000;
        if (wr_en && addr == CCI_STATUS && wstrb[0]) w1c = wdata[3:0];

        cmp0_wr = apply_wstrb(32'(cmp0_q), wdata, wstrb);
        cmp1_wr = apply_wstrb(32'(cmp1_q), wdata, wstrb);

        cmp0_d    = cmp0_q;
        cmp1_d    = cmp1_q;
        ctrl_d    = ctrl_q;
        capture_d = capture_q;
        capcnt_d  = capcnt_q;

        if (wr_en) begin
            case (addr)
                CCI_CMP0: cmp0_d = cmp0_wr[BITS-1:0];
                CCI_CMP1: cmp1_d = cmp1_wr[BITS-1:0];
                CCI_CTRL: if (wstrb[0]) ctrl_d = wdata[CTRL_W-1:0];
                default:  ;
            endcase
        end

        // Hardware set takes priority over a simultaneous W1C.
        pend_d    = (pend_q & ~w1c[2:0]) | hw_set;
        cap_ovf_d = (cap_ovf_q & ~w1c[ST_CAP_OVF]) | (cap_evt & pend_q[ST_PEND_CAP]);

        if (cap_evt) begin
            capture_d = count;
            if (capcnt_q != {CNT_W{1'b1}}) capcnt_d = capcnt_q + CNT_W'(1);
        end

        // Read mux sees pre-update values, so a same-cycle capture returns old data.
        rdata_d = 32'h0;
        if (rd_en) begin
            case (addr)
                CCI_CMP0:    rdata_d = 32'(cmp0_q);
                CCI_CMP1:    rdata_d = 32'(cmp1_q);
                CCI_CTRL:    rdata_d = 32'(ctrl_q);
                CCI_STATUS:  rdata_d = {28'h0, cap_ovf_q, pend_q};
                CCI_CAPTURE: rdata_d = 32'(capture_q);
                CCI_CAPCNT:  rdata_d = 32'(capcnt_q);
                default:     rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp0_q    <= '0;
            cmp1_q    <= '0;
            ctrl_q    <= '0;
            pend_q    <= '0;
            cap_ovf_q <= 1'b0;
            capture_q <= '0;
            capcnt_q  <= '0;
            eq0_q     <= 1'b0;
            eq1_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            cmp0_q    <= cmp0_d;
            cmp1_q    <= cmp1_d;
            ctrl_q    <= ctrl_d;
            pend_q    <= pend_d;
            cap_ovf_q <= cap_ovf_d;
            capture_q <= capture_d;
            capcnt_q  <= capcnt_d;
            eq0_q     <= eq0;
            eq1_q     <= eq1;
            ready_q   <= accept;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        irq           = 3'b000;
        irq[IRQ_CMP0] = pend_q[ST_PEND_CMP0] & ctrl_q[CTRL_EN0];
        irq[IRQ_CMP1] = pend_q[ST_PEND_CMP1] & ctrl_q[CTRL_EN1];
        irq[IRQ_CAP]  = pend_q[ST_PEND_CAP]  & ctrl_q[CTRL_EN_CAP];
    end

    assign ready = ready_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_count_compare_irq.sv
// Self-checking bench for count_compare_irq: directed scenarios with constant
// expectations plus a randomized run against a behavioural register model.
module tb_count_compare_irq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] count = 32'h0BAD_0000;
    logic        evt_in = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready;
    logic [31:0] rdata;
    logic [2:0]  irq;

    int n_checks = 0;
    int n_fail = 0;
    int bus_timeouts = 0;
    bit cnt_run = 1'b0;

    count_compare_irq #(.BITS(32), .CNT_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .count  (count),
        .evt_in (evt_in),
        .valid  (valid),
        .addr   (addr),
        .wstrb  (wstrb),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Free-running counter stimulus, updated shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (cnt_run) count = count + 32'd1;
    end

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_cmp [2];
    logic [3:0]  m_ctrl;
    logic [2:0]  m_pend;
    logic        m_ovf;
    logic [31:0] m_cap;
    logic [15:0] m_capcnt;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        m_prev_hit [2];
    logic [2:0]  lv;   // lv[k] = pad level sampled k+1 edges ago

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_cmp[0];
            3'd1: return m_cmp[1];
            3'd2: return {28'h0, m_ctrl};
            3'd3: return {28'h0, m_ovf, m_pend};
            3'd4: return m_cap;
            3'd5: return {16'h0, m_capcnt};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic       pulse, cap, acc, old_cap_pend;
        logic [2:0] setb;
        logic [3:0] clr;
        if (reset) begin
            m_cmp[0] = 0; m_cmp[1] = 0; m_ctrl = 0; m_pend = 0; m_ovf = 0;
            m_cap = 0; m_capcnt = 0; m_ready = 0; m_rdata = 0;
            m_prev_hit[0] = 0; m_prev_hit[1] = 0; lv = 0;
        end else begin
            // Pad level reaches the detector two edges after being sampled.
            pulse = m_ctrl[3] ? (lv[2] && !lv[1]) : (lv[1] && !lv[2]);
            cap = pulse && m_ctrl[2];
            for (int i = 0; i < 2; i++) begin
                setb[i] = (count == m_cmp[i]) && !m_prev_hit[i];
                m_prev_hit[i] = (count == m_cmp[i]);
            end
            setb[2] = cap;
            acc = valid && !m_ready;
            m_rdata = (acc && wstrb == 4'h0) ? m_read(addr) : 32'h0;
            clr = 4'h0;
            if (acc && wstrb != 4'h0) begin
                case (addr)
                    3'd0, 3'd1:
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) m_cmp[addr[0]][8*b +: 8] = wdata[8*b +: 8];
                    3'd2: if (wstrb[0]) m_ctrl = wdata[3:0];
                    3'd3: if (wstrb[0]) clr = wdata[3:0];
                    default: ;
                endcase
            end
            old_cap_pend = m_pend[2];
            if (cap) begin
                m_cap = count;
                if (m_capcnt != 16'hFFFF) m_capcnt = m_capcnt + 16'd1;
            end
            m_ovf = (m_ovf && !clr[3]) || (cap && old_cap_pend);
            m_pend = (m_pend & ~clr[2:0]) | setb;
            m_ready = acc;
            lv = {lv[1:0], evt_in};
        end
    end

    // ---------------- bus helpers (caller sits just after a posedge) ----------------
    task automatic bus(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd_val);
        bit got = 0;
        rd_val = 32'h0;
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin got = 1; rd_val = rdata; end
        end
        if (!got) bus_timeouts++;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, s, d, dummy);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus(a, 4'h0, 32'h0, d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; valid = 1'b0; wstrb = 4'h0; addr = 3'd0; wdata = 32'h0;
        evt_in = 1'b0; cnt_run = 1'b0; count = 32'h0BAD_0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        @(negedge clk);
        n_checks++;
        if (irq !== 3'b000 || ready !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b ready=%b rdata=0x%0h, expected 0/0/0",
                     irq, ready, rdata);
        end
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got 0x%0h, expected 0x0", a, d);
            end
        end
    endtask

    task automatic test_compare0();
        bit found = 0;
        bit stayed_low = 1;
        count = 32'h5;
        do_reset();
        count = 32'h5;
        wr(3'd0, 4'hF, 32'h10);
        wr(3'd2, 4'hF, 32'h1);
        count = 32'h0;
        cnt_run = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (count == 32'h10) found = 1;
        end
        n_checks++;
        if (!found || irq[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp0_before: found=%0d irq0=%b, expected 1/0", found, irq[0]);
        end
        @(negedge clk);
        n_checks++;
        if (irq[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp0_rise: irq0=%b, expected 1", irq[0]);
        end
        @(posedge clk); #1;
        wr(3'd3, 4'hF, 32'h1);
        @(negedge clk);
        n_checks++;
        if (irq[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp0_w1c: irq0=%b, expected 0", irq[0]);
        end
        // Let the 32-bit counter wrap through zero back to 0x10.
        @(posedge clk); #1;
        count = 32'hFFFF_FFF0;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (irq[0] !== 1'b0) stayed_low = 0;
            if (count == 32'h10) found = 1;
        end
        n_checks++;
        if (!found || !stayed_low) begin
            n_fail++;
            $display("FAIL cmp0_wrap_low: found=%0d stayed_low=%0d, expected 1/1",
                     found, stayed_low);
        end
        @(negedge clk);
        n_checks++;
        if (irq[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp0_wrap_rise: irq0=%b, expected 1", irq[0]);
        end
        @(posedge clk); #1 cnt_run = 1'b0;
    endtask

    task automatic test_compare_hold();
        logic [31:0] d;
        do_reset();
        count = 32'h20;
        wr(3'd1, 4'hF, 32'h20);
        rd(3'd3, d);
        n_checks++;
        if (d !== 32'h2 || irq !== 3'b000) begin
            n_fail++;
            $display("FAIL cmp1_hold_set: status=0x%0h irq=%b, expected 0x2/000", d, irq);
        end
        wr(3'd3, 4'hF, 32'h2);
        repeat (6) @(posedge clk);
        #1;
        rd(3'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL cmp1_hold_once: status=0x%0h, expected 0x0", d);
        end
    endtask

    task automatic test_capture();
        logic [31:0] d;
        do_reset();
        count = 32'h50;
        wr(3'd2, 4'hF, 32'h4);
        evt_in = 1'b1;
        count = 32'hFE;
        @(negedge clk);
        n_checks++;
        if (irq[2] !== 1'b0) begin
            n_fail++; $display("FAIL cap_irq_e0: irq2=%b, expected 0", irq[2]);
        end
        @(posedge clk); #1 count = 32'hFF;
        @(negedge clk);
        n_checks++;
        if (irq[2] !== 1'b0) begin
            n_fail++; $display("FAIL cap_irq_e1: irq2=%b, expected 0", irq[2]);
        end
        @(posedge clk); #1 count = 32'h100;
        @(negedge clk);
        n_checks++;
        if (irq[2] !== 1'b0) begin
            n_fail++; $display("FAIL cap_irq_e2: irq2=%b, expected 0", irq[2]);
        end
        @(posedge clk); #1 count = 32'h101;
        @(negedge clk);
        n_checks++;
        if (irq[2] !== 1'b1) begin
            n_fail++; $display("FAIL cap_irq_e3: irq2=%b, expected 1", irq[2]);
        end
        @(posedge clk); #1;
        rd(3'd4, d);
        n_checks++;
        if (d !== 32'h100) begin
            n_fail++; $display("FAIL cap_value: got 0x%0h, expected 0x100", d);
        end
        rd(3'd5, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL cap_count1: got 0x%0h, expected 0x1", d);
        end
        // Second rising edge before the pending bit is cleared.
        evt_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 evt_in = 1'b1; count = 32'h200;
        repeat (5) @(posedge clk);
        #1;
        rd(3'd3, d);
        n_checks++;
        if (d !== 32'hC) begin
            n_fail++; $display("FAIL cap_ovf: status=0x%0h, expected 0xC", d);
        end
        rd(3'd5, d);
        n_checks++;
        if (d !== 32'h2) begin
            n_fail++; $display("FAIL cap_count2: got 0x%0h, expected 0x2", d);
        end
        rd(3'd4, d);
        n_checks++;
        if (d !== 32'h200) begin
            n_fail++; $display("FAIL cap_value2: got 0x%0h, expected 0x200", d);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        do_reset();
        count = 32'h55;
        wr(3'd0, 4'hF, 32'h55);
        count = 32'h54;
        @(posedge clk); #1;
        count = 32'h55;
        wr(3'd3, 4'hF, 32'h1);   // W1C in the same cycle as a fresh match
        rd(3'd3, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL set_wins: status=0x%0h, expected 0x1", d);
        end
        wr(3'd3, 4'hF, 32'h1);
        rd(3'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL plain_w1c: status=0x%0h, expected 0x0", d);
        end
        wr(3'd0, 4'hF, 32'h1122_3344);
        wr(3'd0, 4'b0010, 32'h0000_AB00);
        rd(3'd0, d);
        n_checks++;
        if (d !== 32'h1122_AB44) begin
            n_fail++; $display("FAIL byte_write: got 0x%0h, expected 0x1122ab44", d);
        end
        wr(3'd4, 4'hF, 32'hFFFF_FFFF);
        wr(3'd6, 4'hF, 32'hFFFF_FFFF);
        rd(3'd4, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL ro_capture: got 0x%0h, expected 0x0", d);
        end
        rd(3'd6, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL idx6: got 0x%0h, expected 0x0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_rdy;
        do_reset();
        count = 32'h77;
        wr(3'd0, 4'hF, 32'hCAFE);
        valid = 1'b1; addr = 3'd0; wstrb = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_rdy = (i % 2 == 1);
            n_checks++;
            if (ready !== exp_rdy || (exp_rdy && rdata !== 32'hCAFE)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: ready=%b rdata=0x%0h, expected %b/0xcafe",
                         i, ready, rdata, exp_rdy);
            end
        end
        @(posedge clk); #1 valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        do_reset();
        count = 32'h30;
        wr(3'd2, 4'hF, 32'h7);
        wr(3'd0, 4'hF, 32'h30);
        wr(3'd1, 4'hF, 32'h30);
        evt_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (irq !== 3'b111) begin
            n_fail++; $display("FAIL pre_reset_irq: irq=%b, expected 111", irq);
        end
        @(posedge clk); #1;
        valid = 1'b1; addr = 3'd5; wstrb = 4'h0; reset = 1'b1; evt_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (irq !== 3'b000 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: irq=%b ready=%b, expected 000/0", irq, ready);
        end
        @(posedge clk); #1;
        reset = 1'b0; valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL dropped_access: ready=%b, expected 0", ready);
        end
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL post_reset_read[%0d]: got 0x%0h, expected 0x0", a, d);
            end
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        count = 32'h0;
        for (int c = 0; c < 800; c++) begin
            valid = ($urandom_range(0, 2) == 0);
            addr  = 3'($urandom_range(0, 7));
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            r = $urandom_range(0, 7);
            if (r >= 3 && r <= 5) count = count + 32'd1;
            else if (r == 6) count = m_cmp[$urandom_range(0, 1)];
            else if (r == 7) count = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) evt_in = ~evt_in;
            @(negedge clk);
            n_checks++;
            if (irq !== (m_pend & m_ctrl[2:0]) || ready !== m_ready ||
                (m_ready && rdata !== m_rdata)) begin
                n_fail++;
                $display("FAIL random[%0d]: irq=%b ready=%b rdata=0x%0h, expected %b/%b/0x%0h",
                         c, irq, ready, rdata, m_pend & m_ctrl[2:0], m_ready, m_rdata);
            end
            @(posedge clk); #1;
        end
        valid = 1'b0; wstrb = 4'h0;
    endtask

    initial begin
        test_reset();
        test_compare0();
        test_compare_hold();
        test_capture();
        test_simultaneous();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        n_checks++;
        if (bus_timeouts !== 0) begin
            n_fail++;
            $display("FAIL bus_ready: %0d accesses without ready, expected 0", bus_timeouts);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
